cgra_config_loader: RTL
=======================

# cgra_config_loader

Configuration front-end for the PE array. Accepts control words as a 4-bit nibble stream from the chip pins over a valid/ready handshake and assembles them into a shadow buffer of one 8-bit word per PE. It then commits the whole buffer atomically to the `ctrl_out` bus, which drives each PE's `ctrl_signals_in`, and gates the PE array's shared `en`.

## Interface
- `NUM_PE`, default 4: number of PEs configured; each owns one word.
- `CTRL_W`, default 8: control word width; must equal the PE control register width.
- `NIB_W`, default 4: pin-side transfer width; `CTRL_W` must equal 2×`NIB_W`.
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `cfg_start` in 1: begin a new load; honoured only in IDLE.
- `cfg_valid` in 1: `cfg_data` holds a nibble.
- `cfg_data` in `NIB_W`: nibble stream, high nibble of each word first, PE0 first.
- `cfg_ready` out 1: loader accepts a nibble this cycle.
- `run_req` in 1: request that the array compute.
- `pe_en` out 1: shared enable to all PEs.
- `ctrl_out` out `NUM_PE`×`CTRL_W`: committed words; PE i uses bits [i×8+7 : i×8].
- `busy` out 1: high in any state other than IDLE.
- `cfg_done` out 1: a valid configuration has been committed.
- `cfg_error` out 1: sticky parity error (see Configuration).

## Operation
- States: IDLE, LOAD_HI, LOAD_LO, LOAD_PAR (only with the macro), COMMIT.
- A transfer occurs on a rising edge where `cfg_valid && cfg_ready`. `cfg_ready` = 1 exactly in LOAD_HI, LOAD_LO and LOAD_PAR.
- IDLE:
  - `cfg_start` → LOAD_HI.
  - On that transition: `pe_idx` = 0, `cfg_error` cleared, shadow buffer left as is.
- LOAD_HI: on transfer, `shadow[pe_idx][7:4]` = `cfg_data` → LOAD_LO.
- LOAD_LO: on transfer, `shadow[pe_idx][3:0]` = `cfg_data`.
  - Without the macro: if `pe_idx` = `NUM_PE`−1 → COMMIT; otherwise `pe_idx`++ → LOAD_HI.
  - With the macro: → LOAD_PAR.
- No transfer (`cfg_valid` low): state and buffer hold indefinitely; there is no timeout.
- COMMIT: on the exit edge, `ctrl_out` = whole shadow buffer, `cfg_done` = 1 → IDLE.
- `pe_en` = `run_req && cfg_done && state != COMMIT`.
  - The array keeps running on the old configuration during LOAD_* because `ctrl_out` is double-buffered.
- `cfg_start` in any LOAD_* state or in COMMIT is ignored.
- `pe_idx` width is clog2(`NUM_PE`), minimum 1. It never wraps past `NUM_PE`−1.
- Reset values: state = IDLE, `pe_idx` = 0, shadow = 0, `ctrl_out` = 0, `cfg_done` = 0, `cfg_error` = 0, `cfg_ready` = 0, `pe_en` = 0, `busy` = 0.
- Reset mid-load discards the partial load. PEs see `ctrl_out` = 0 and `pe_en` = 0 immediately (asynchronous).

## Timing
- Minimum load is 2×`NUM_PE` transfer cycles (3×`NUM_PE` with the macro), plus 1 COMMIT cycle.
- Last transfer edge → state = COMMIT. `pe_en` is forced low for that one cycle.
- Next edge → new `ctrl_out` visible, `cfg_done` = 1, IDLE.
- The first PE capture of the new words happens on the next edge with `pe_en` = 1.
- `cfg_ready` is a registered-state decode with no combinational path from `cfg_valid`.
- `pe_en` is combinational from `run_req` and registered state.
- `ctrl_out` is registered and changes only on the COMMIT exit edge or on reset.

## Configuration
- Macro: `CGRA_CFG_PARITY_EN`.
- Defined:
  - After each word's low nibble, one parity nibble is transferred (LOAD_PAR). Its bit 0 must equal the XOR of the 8 word bits; bits 3:1 are ignored.
  - Match → next word, or COMMIT after the last word.
  - Mismatch → IDLE with `cfg_error` = 1. No commit: `ctrl_out` and `cfg_done` are unchanged.
  - `cfg_error` stays set until the next accepted `cfg_start`.
- Undefined: LOAD_PAR does not exist and `cfg_error` is tied to 0.

## Structure
- Package `cgra_cfg_pkg`:
  - `cfg_state_t` enum.
  - `CTRL_W` and `NIB_W` localparams.
  - Field positions of the PE control word: `alu_op` [1:0], `sel_op_1` [4:2], `sel_op_0` [7:5].
  - `ALU_OR`/`ALU_AND`/`ALU_XOR`/`ALU_SHL` op codes for benches.
- One sub-module, `cfg_word_assembler`: nibble-pair to word assembly plus parity check. Shadow buffer, commit register and FSM live in the top level.

## Test plan
- Reset, then load `NUM_PE`=4 words 0xA5, 0x3C, 0x00, 0xFF with `cfg_valid` held high → `cfg_ready` high for 8 cycles, COMMIT, then `ctrl_out` = 0xFF003CA5 and `cfg_done` = 1.
- Same load with `cfg_valid` dropped for 3 cycles after the 5th nibble → identical final `ctrl_out`; state holds during the gap.
- `run_req` = 1 with an old configuration committed while a new load runs → `pe_en` = 1 throughout LOAD_*, 0 in the COMMIT cycle, 1 afterwards; `ctrl_out` changes only after COMMIT.
- Assert `reset` after 3 nibbles of a load → `ctrl_out` = 0, `cfg_done` = 0 and `pe_en` = 0 immediately; the next full load succeeds.
- `cfg_start` pulsed mid-load → ignored, `pe_idx` unaffected, load completes normally.
- With `CGRA_CFG_PARITY_EN`: word 0xA5 with parity nibble 0x1 (correct parity is 0) → `cfg_error` = 1, IDLE, `ctrl_out` unchanged; a following `cfg_start` clears `cfg_error`.

Source files
------------

// File: rtl/cgra_cfg_pkg.sv
// Shared types and constants for the CGRA configuration loader and its benches.
// The parity-protected load is enabled by defining CGRA_CFG_PARITY_EN.
package cgra_cfg_pkg;

    localparam int CTRL_W = 8;
    localparam int NIB_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_HI,
        ST_LOAD_LO,
        ST_LOAD_PAR,
        ST_COMMIT
    } cfg_state_t;

    // Field layout of one PE control word.
    localparam int ALU_OP_LSB   = 0;
    localparam int ALU_OP_MSB   = 1;
    localparam int SEL_OP_1_LSB = 2;
    localparam int SEL_OP_1_MSB = 4;
    localparam int SEL_OP_0_LSB = 5;
    localparam int SEL_OP_0_MSB = 7;

    localparam logic [1:0] ALU_OR  = 2'd0;
    localparam logic [1:0] ALU_AND = 2'd1;
    localparam logic [1:0] ALU_XOR = 2'd2;
    localparam logic [1:0] ALU_SHL = 2'd3;

endpackage

// File: rtl/cfg_word_assembler.sv
// Merges one pin nibble into the high or low half of a PE control word and,
// when CGRA_CFG_PARITY_EN is defined, checks a parity nibble against that word.
module cfg_word_assembler #(
    parameter int NIB_W = cgra_cfg_pkg::NIB_W
) (
    input  logic [2*NIB_W-1:0] cur_word_i,
    input  logic [NIB_W-1:0]   nib_i,
    input  logic               load_lo_i,
`ifdef CGRA_CFG_PARITY_EN
    output logic               par_ok_o,
`endif
    output logic [2*NIB_W-1:0] word_o
);

    always_comb begin
        // NOTE: assigning the full default first means every path drives
        // word_o, so no latch can be inferred from the partial updates below.
        word_o = cur_word_i;
        if (load_lo_i) begin
            word_o[NIB_W-1:0] = nib_i;
        end else begin
            word_o[2*NIB_W-1:NIB_W] = nib_i;
        end
    end

`ifdef CGRA_CFG_PARITY_EN
    // Only bit 0 of the parity nibble carries information.
    assign par_ok_o = (nib_i[0] == ^cur_word_i);
`endif

endmodule

// File: rtl/cgra_config_loader.sv
// Nibble-stream configuration loader with a shadow buffer and atomic commit
// to the PE control bus. Define CGRA_CFG_PARITY_EN for per-word parity.
module cgra_config_loader #(
    parameter int NUM_PE = 4,
    parameter int CTRL_W = cgra_cfg_pkg::CTRL_W,
    parameter int NIB_W  = cgra_cfg_pkg::NIB_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_start,
    input  logic                     cfg_valid,
    input  logic [NIB_W-1:0]         cfg_data,
    output logic                     cfg_ready,
    input  logic                     run_req,
    output logic                     pe_en,
    output logic [NUM_PE*CTRL_W-1:0] ctrl_out,
    output logic                     busy,
    output logic                     cfg_done,
    output logic                     cfg_error
);

    import cgra_cfg_pkg::cfg_state_t;
    import cgra_cfg_pkg::ST_IDLE;
    import cgra_cfg_pkg::ST_LOAD_HI;
    import cgra_cfg_pkg::ST_LOAD_LO;
    import cgra_cfg_pkg::ST_LOAD_PAR;
    import cgra_cfg_pkg::ST_COMMIT;

    localparam int               IDX_W    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    cfg_state_t               state_q;
    logic [IDX_W-1:0]         pe_idx_q;
    logic [CTRL_W-1:0]        shadow_q [NUM_PE];
    logic [NUM_PE*CTRL_W-1:0] ctrl_out_q;
    logic                     cfg_done_q;
    logic [CTRL_W-1:0]        shadow_d;

`ifdef CGRA_CFG_PARITY_EN
    logic cfg_error_q;
    logic par_ok;
`endif

    cfg_word_assembler #(
        .NIB_W (NIB_W)
    ) u_word_assembler (
        .cur_word_i (shadow_q[pe_idx_q]),
        .nib_i      (cfg_data),
        .load_lo_i  (state_q == ST_LOAD_LO),
`ifdef CGRA_CFG_PARITY_EN
        .par_ok_o   (par_ok),
`endif
        .word_o     (shadow_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pe_idx_q   <= '0;
            ctrl_out_q <= '0;
            cfg_done_q <= 1'b0;
            // NOTE: the shadow buffer must read as zero after reset, so it is
            // built from resettable flops rather than an unreset memory.
            for (int i = 0; i < NUM_PE; i++) begin
                shadow_q[i] <= '0;
            end
`ifdef CGRA_CFG_PARITY_EN
            cfg_error_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values, independent of statement order.
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state_q  <= ST_LOAD_HI;
                        pe_idx_q <= '0;
`ifdef CGRA_CFG_PARITY_EN
                        cfg_error_q <= 1'b0;
`endif
                    end
                end
                ST_LOAD_HI: begin
                    if (cfg_valid) begin
                        shadow_q[pe_idx_q] <= shadow_d;
                        state_q            <= ST_LOAD_LO;
                    end
                end
                ST_LOAD_LO: begin
                    if (cfg_valid) begin
                        shadow_q[pe_idx_q] <= shadow_d;
`ifdef CGRA_CFG_PARITY_EN
                        state_q <= ST_LOAD_PAR;
`else
                        if (pe_idx_q == LAST_IDX) begin
                            state_q <= ST_COMMIT;
                        end else begin
                            pe_idx_q <= pe_idx_q + 1'b1;
                            state_q  <= ST_LOAD_HI;
                        end
`endif
                    end
                end
`ifdef CGRA_CFG_PARITY_EN
                ST_LOAD_PAR: begin
                    if (cfg_valid) begin
                        if (!par_ok) begin
                            // Abandon the load; the committed words stay live.
                            state_q     <= ST_IDLE;
                            cfg_error_q <= 1'b1;
                        end else if (pe_idx_q == LAST_IDX) begin
                            state_q <= ST_COMMIT;
                        end else begin
                            pe_idx_q <= pe_idx_q + 1'b1;
                            state_q  <= ST_LOAD_HI;
                        end
                    end
                end
`endif
                ST_COMMIT: begin
                    for (int i = 0; i < NUM_PE; i++) begin
                        ctrl_out_q[i*CTRL_W +: CTRL_W] <= shadow_q[i];
                    end
                    cfg_done_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_ready = (state_q == ST_LOAD_HI) || (state_q == ST_LOAD_LO) ||
                       (state_q == ST_LOAD_PAR);
    assign busy      = (state_q != ST_IDLE);
    assign ctrl_out  = ctrl_out_q;
    assign cfg_done  = cfg_done_q;
    // The array is held off for the single cycle in which ctrl_out swaps.
    assign pe_en     = run_req && cfg_done_q && (state_q != ST_COMMIT);

`ifdef CGRA_CFG_PARITY_EN
    assign cfg_error = cfg_error_q;
`else
    assign cfg_error = 1'b0;
`endif

endmodule
